// File: rtl/cla_subtractor.sv
// cla_subtractor
//   Two-stage pipelined WIDTH-bit carry-lookahead subtractor on a valid/ready
//   stream. Computes d = a - b - bin as a + ~b + ~bin and reports borrow
//   (inverted carry) and signed overflow for every beat.
//
//   Ports
//     i_clk        rising-edge clock
//     i_rst        asynchronous active-high reset
//     i_in_valid   operand beat offered
//     o_in_ready   operand beat can be accepted this cycle
//     i_a, i_b     minuend, subtrahend
//     i_bin        borrow in (1 = subtract one more)
//     o_out_valid  result beat present
//     i_out_ready  sink accepts the result beat this cycle
//     o_d          difference mod 2^WIDTH
//     o_bout       borrow out (unsigned a < b + bin)
//     o_ovf        signed overflow
module cla_subtractor #(
    parameter int WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_d,
    output logic             o_bout,
    output logic             o_ovf
);

    // Stage 1: propagate/generate of a + ~b, carry-in ~bin, operand sign bits
    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_p;
    logic [WIDTH-1:0] r_s1_g;
    logic             r_s1_c0;
    logic             r_s1_a_msb;
    logic             r_s1_b_msb;

    // Stage 2: registered result
    logic             r_s2_v;
    logic [WIDTH-1:0] r_s2_d;
    logic             r_s2_bout;
    logic             r_s2_ovf;

    logic             w_adv1;
    logic             w_adv2;
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_d;
    logic             w_bout;
    logic             w_ovf;

    // Ready depends only on pipeline occupancy and the sink, never on i_in_valid.
    assign w_adv2     = ~r_s2_v | i_out_ready;
    assign w_adv1     = ~r_s1_v | w_adv2;
    assign o_in_ready = w_adv1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_v     <= 1'b0;
            r_s1_p     <= '0;
            r_s1_g     <= '0;
            r_s1_c0    <= 1'b0;
            r_s1_a_msb <= 1'b0;
            r_s1_b_msb <= 1'b0;
        end else if (w_adv1) begin
            r_s1_v <= i_in_valid;
            if (i_in_valid) begin
                r_s1_p     <= i_a ^ ~i_b;
                r_s1_g     <= i_a & ~i_b;
                r_s1_c0    <= ~i_bin;
                r_s1_a_msb <= i_a[WIDTH-1];
                r_s1_b_msb <= i_b[WIDTH-1];
            end
        end
    end

    // Each carry is expanded into its full sum of products:
    //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]c0
    // so no carry term depends on another computed carry.
    always_comb begin : carry_lookahead
        logic v_sum;
        logic v_term;
        v_sum  = 1'b0;
        v_term = 1'b0;
        w_c    = '0;
        w_c[0] = r_s1_c0;
        for (int i = 0; i < WIDTH; i++) begin
            v_term = r_s1_c0;
            for (int k = 0; k <= i; k++) begin
                v_term = v_term & r_s1_p[k];
            end
            v_sum = v_term;
            for (int j = 0; j <= i; j++) begin
                v_term = r_s1_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    v_term = v_term & r_s1_p[k];
                end
                v_sum = v_sum | v_term;
            end
            w_c[i+1] = v_sum;
        end
    end

    assign w_d    = r_s1_p ^ w_c[WIDTH-1:0];
    assign w_bout = ~w_c[WIDTH];
    assign w_ovf  = (r_s1_a_msb ^ r_s1_b_msb) & (w_d[WIDTH-1] ^ r_s1_a_msb);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_v    <= 1'b0;
            r_s2_d    <= '0;
            r_s2_bout <= 1'b0;
            r_s2_ovf  <= 1'b0;
        end else if (w_adv2) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_d    <= w_d;
                r_s2_bout <= w_bout;
                r_s2_ovf  <= w_ovf;
            end
        end
    end

    assign o_out_valid = r_s2_v;
    assign o_d         = r_s2_d;
    assign o_bout      = r_s2_bout;
    assign o_ovf       = r_s2_ovf;

endmodule

// File: tb/tb_cla_subtractor.sv
module tb_cla_subtractor;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    int           errors = 0;
    int           checks = 0;
    int           outs   = 0;
    logic         acc_flag;
    logic [7:0]   q[$];

    always #5 clk = ~clk;

    cla_subtractor #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_a        (a),
        .i_b        (b),
        .i_bin      (bin),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_d        (d),
        .o_bout     (bout),
        .o_ovf      (ovf)
    );

    // Reference: plain 7-bit subtraction; bit 6 is the borrow.
    function automatic logic [7:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
        logic [6:0]   diff;
        logic [W-1:0] md;
        logic         mo;
        diff = {1'b0, ma} - {1'b0, mb} - {6'd0, mbin};
        md   = diff[5:0];
        mo   = (ma[5] != mb[5]) && (md[5] != ma[5]);
        return {md, diff[6], mo};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with scoreboard bookkeeping; inputs are set at the negedge before calling.
    task automatic cycle();
        #1;
        acc_flag = in_valid && in_ready;
        if (acc_flag) q.push_back(model(a, b, bin));
        if (out_valid && out_ready) begin
            outs++;
            if (q.size() == 0) chk("sb_unexpected_beat", 16'(q.size()), 16'd1);
            else               chk("sb_data", {8'd0, d, bout, ovf}, {8'd0, q.pop_front()});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single beat with hand-computed result; result visible after the second edge
    // counting the accepting one.
    task automatic single(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                          input logic [W-1:0] ed, input logic eb, input logic eo,
                          input string tag);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a = ta; b = tb; bin = tbin;
        #1 chk({tag, "_in_ready"}, 16'(in_ready), 16'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat_early"}, 16'(out_valid), 16'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, 16'(out_valid), 16'd1);
        chk({tag, "_result"}, {8'd0, d, bout, ovf}, {8'd0, ed, eb, eo});
    endtask

    initial begin
        int         base;
        int         acc;
        int         idx;
        int         cyc;
        logic [7:0] snap;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_result", {8'd0, d, bout, ovf}, 16'd0);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", 16'(in_ready), 16'd1);
        @(negedge clk);

        single(6'h00, 6'h01, 1'b0, 6'h3F, 1'b1, 1'b0, "zero_minus_one");
        single(6'h20, 6'h01, 1'b0, 6'h1F, 1'b0, 1'b1, "neg_ovf");
        single(6'h1F, 6'h3F, 1'b0, 6'h20, 1'b1, 1'b1, "pos_ovf");
        single(6'h15, 6'h15, 1'b1, 6'h3F, 1'b1, 1'b0, "equal_bin1");
        single(6'h15, 6'h15, 1'b0, 6'h00, 1'b0, 1'b0, "equal_bin0");
        @(negedge clk);
        q.delete();

        // Back-to-back stream of 8 beats
        base = outs;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i >= 2) chk("stream_consecutive", 16'(out_valid), 16'd1);
            in_valid = 1'b1;
            a = 6'(i * 7 + 3); b = 6'(i * 11 + 5); bin = 1'(i);
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stream_tail", 16'(out_valid), 16'd1);
            cycle();
        end
        chk("stream_count", 16'(outs - base), 16'd8);
        chk("stream_queue_empty", 16'(q.size()), 16'd0);

        // Backpressure: only two beats fit, output held stable
        base = outs;
        acc  = 0;
        snap = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a = 6'(i * 13 + 40); b = 6'(i * 5 + 9); bin = 1'(i + 1);
            cycle();
            if (acc_flag) acc++;
            if (i == 1) snap = {d, bout, ovf};
        end
        #1;
        chk("bp_accepted", 16'(acc), 16'd2);
        chk("bp_in_ready", 16'(in_ready), 16'd0);
        chk("bp_out_valid", 16'(out_valid), 16'd1);
        chk("bp_stable", {8'd0, d, bout, ovf}, {8'd0, snap});
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("bp_release_count", 16'(outs - base), 16'd2);
        chk("bp_queue_empty", 16'(q.size()), 16'd0);

        // Mid-stream reset with two beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            a = 6'(i + 11); b = 6'(i + 2); bin = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        chk("inflight_valid", 16'(out_valid), 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 16'(out_valid), 16'd0);
        chk("async_rst_result", {8'd0, d, bout, ovf}, 16'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        single(6'h3F, 6'h00, 1'b0, 6'h3F, 1'b0, 1'b0, "post_rst_beat");
        @(negedge clk);
        q.delete();

        // Exhaustive operands with random handshakes
        base = outs;
        idx  = 0;
        cyc  = 0;
        while (idx < 8192 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = idx[12:7];
            b   = idx[6:1];
            bin = idx[0];
            cycle();
            cyc++;
            if (acc_flag) idx++;
        end
        chk("exh_all_accepted", 16'(idx), 16'd8192);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) cycle();
        chk("exh_queue_empty", 16'(q.size()), 16'd0);
        chk("exh_out_count", 16'(outs - base), 16'(idx));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
